// File: rtl/ifu_fetch_pkg.sv
// Shared fetch types: npc_op encodings, fetch FSM states, reset PC.
// Imported by the fetch unit and the decoder.
package ifu_fetch_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_BEQ = 3'b001;
  localparam logic [2:0] NPC_JAL = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// Next-PC computation for the fetch unit (combinational).
// In: pc, instr[25:0], npc_op, br_eq, jr_target. Out: npc, misaligned.
module ifu_fetch_npc_calc
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_instr,
  input  logic [2:0]  i_npc_op,
  input  logic        i_br_eq,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_npc,
  output logic        o_misaligned
);

  logic [31:0] w_seq;
  logic [31:0] w_boff;

  assign w_seq  = i_pc + 32'd4;
  assign w_boff = {{14{i_instr[15]}},
                   i_instr[15:0], 2'b00};

  always_comb begin
    o_npc = w_seq;
    case (i_npc_op)
      NPC_BEQ: o_npc = i_br_eq ? (w_seq + w_boff)
                               : w_seq;
      NPC_JAL: o_npc = {i_pc[31:28], i_instr, 2'b00};
      NPC_JR:  o_npc = i_jr_target;
      default: o_npc = w_seq;
    endcase
  end

  assign o_misaligned = |o_npc[1:0];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, one outstanding imem read,
// hands words to decode. Ports: imem req/rsp, instr to decode, npc ctrl.
module ifu_fetch #(
  parameter logic [31:0] PC_RESET = ifu_fetch_pkg::PC_RESET,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] link_pc,
  input  logic [2:0]        npc_op,
  input  logic              br_eq,
  input  logic [31:0]       jr_target,
  output logic              fault,
  output logic [31:0]       retire_cnt
);

  import ifu_fetch_pkg::*;

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_req_valid;
  logic              r_instr_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_fault;
  logic [31:0]       r_retire;

  logic [31:0]       w_npc;
  logic              w_misaligned;

  ifu_fetch_npc_calc u_npc (
    .i_pc        (r_pc),
    .i_instr     (r_instr[25:0]),
    .i_npc_op    (npc_op),
    .i_br_eq     (br_eq),
    .i_jr_target (jr_target),
    .o_npc       (w_npc),
    .o_misaligned(w_misaligned)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_pc          <= PC_RESET;
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= PC_RESET;
      r_fault       <= 1'b0;
      r_retire      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state     <= S_REQ;
          r_req_valid <= 1'b1;
        end
        S_REQ: begin
          if (imem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_instr       <= imem_rsp_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            r_retire      <= r_retire + 32'd1;
            r_instr_valid <= 1'b0;
            // Bad jr target: keep pc, park until reset.
            if (w_misaligned) begin
              r_fault <= 1'b1;
              r_state <= S_FAULT;
            end else begin
              r_pc        <= w_npc;
              r_req_valid <= 1'b1;
              r_state     <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_addr      = r_pc;
  assign instr_valid    = r_instr_valid;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign link_pc        = r_instr_pc + 32'd4;
  assign fault          = r_fault;
  assign retire_cnt     = r_retire;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: vector table of fetch transactions
// plus hand sequences for fault, reset pulse and async reset in WAIT.
module tb_ifu_fetch;

  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] link_pc;
  logic [2:0]  npc_op;
  logic        br_eq;
  logic [31:0] jr_target;
  logic        fault;
  logic [31:0] retire_cnt;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .link_pc       (link_pc),
    .npc_op        (npc_op),
    .br_eq         (br_eq),
    .jr_target     (jr_target),
    .fault         (fault),
    .retire_cnt    (retire_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [2:0]  op;
    logic        beq;
    logic [31:0] jr;
    logic [31:0] npc;
    int          sreq;
    int          drsp;
    int          shold;
  } vec_t;

  vec_t v[11];
  vec_t fv;
  vec_t r0;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;
  int exp_req = 0;
  int req_cnt;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) req_cnt <= 0;
    else if (imem_req_valid && imem_req_ready)
      req_cnt <= req_cnt + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  task automatic fetch(input vec_t t, input bit exp_fault);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, t.pc);
    for (int k = 0; k < t.sreq; k++) begin
      @(negedge clk);
      chk("stall_req_valid",
          {31'd0, imem_req_valid}, 32'd1);
      chk("stall_req_addr", imem_addr, t.pc);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    exp_req++;
    chk("req_drop", {31'd0, imem_req_valid}, 32'd0);
    for (int k = 1; k < t.drsp; k++) begin
      @(negedge clk);
      chk("wait_req", {31'd0, imem_req_valid}, 32'd0);
      chk("wait_ivalid", {31'd0, instr_valid}, 32'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = t.data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    chk("hold_ivalid", {31'd0, instr_valid}, 32'd1);
    chk("hold_instr", instr, t.data);
    chk("hold_pc", instr_pc, t.pc);
    chk("link_pc", link_pc, t.pc + 32'd4);
    chk("req_count", req_cnt, exp_req);
    for (int k = 0; k < t.shold; k++) begin
      if (k == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      chk("stall_ivalid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, t.data);
      chk("stall_pc", instr_pc, t.pc);
      chk("stall_req", {31'd0, imem_req_valid}, 32'd0);
    end
    npc_op      = t.op;
    br_eq       = t.beq;
    jr_target   = t.jr;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    npc_op      = NPC_SEQ;
    br_eq       = 1'b0;
    jr_target   = 32'h0;
    exp_ret++;
    chk("retire_cnt", retire_cnt, exp_ret);
    chk("acc_ivalid", {31'd0, instr_valid}, 32'd0);
    if (exp_fault) begin
      chk("fault_set", {31'd0, fault}, 32'd1);
      chk("fault_req", {31'd0, imem_req_valid}, 32'd0);
    end else begin
      chk("no_fault", {31'd0, fault}, 32'd0);
      chk("next_req", {31'd0, imem_req_valid}, 32'd1);
      chk("next_addr", imem_addr, t.npc);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_reqv"}, {31'd0, imem_req_valid}, 32'd0);
    chk({nm, "_addr"}, imem_addr, 32'h3000);
    chk({nm, "_ivalid"}, {31'd0, instr_valid}, 32'd0);
    chk({nm, "_instr"}, instr, 32'h0);
    chk({nm, "_ipc"}, instr_pc, 32'h3000);
    chk({nm, "_link"}, link_pc, 32'h3004);
    chk({nm, "_fault"}, {31'd0, fault}, 32'd0);
    chk({nm, "_retire"}, retire_cnt, 32'd0);
  endtask

  initial begin
    v[0]  = '{32'h3000, 32'h3402_0001, NPC_SEQ, 1'b0,
              32'h0, 32'h3004, 0, 1, 0};
    v[1]  = '{32'h3004, 32'h0000_0000, NPC_SEQ, 1'b0,
              32'h0, 32'h3008, 3, 4, 5};
    v[2]  = '{32'h3008, 32'h0123_4567, NPC_SEQ, 1'b0,
              32'h0, 32'h300C, 0, 1, 2};
    v[3]  = '{32'h300C, 32'h0000_0000, NPC_SEQ, 1'b0,
              32'h0, 32'h3010, 0, 2, 0};
    v[4]  = '{32'h3010, 32'h1000_FFFE, NPC_BEQ, 1'b1,
              32'h0, 32'h300C, 0, 1, 0};
    v[5]  = '{32'h300C, 32'h0000_0000, NPC_SEQ, 1'b0,
              32'h0, 32'h3010, 1, 1, 0};
    v[6]  = '{32'h3010, 32'h1000_FFFE, NPC_BEQ, 1'b0,
              32'h0, 32'h3014, 0, 1, 0};
    v[7]  = '{32'h3014, 32'h0000_0008, NPC_JR, 1'b0,
              32'h3020, 32'h3020, 0, 1, 0};
    v[8]  = '{32'h3020, 32'h0C00_0C10, NPC_JAL, 1'b0,
              32'h0, 32'h3040, 0, 1, 0};
    v[9]  = '{32'h3040, 32'h0000_0008, NPC_JR, 1'b0,
              32'h3100, 32'h3100, 0, 1, 0};
    v[10] = '{32'h3100, 32'h0000_FFFF, 3'b011, 1'b1,
              32'h5555, 32'h3104, 0, 1, 0};
    fv    = '{32'h3104, 32'h0000_0008, NPC_JR, 1'b0,
              32'h3102, 32'h0, 0, 1, 0};
    r0    = v[0];

    reset_n        = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b0;
    npc_op         = NPC_SEQ;
    br_eq          = 1'b0;
    jr_target      = 32'h0;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) fetch(v[i], 1'b0);

    fetch(fv, 1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("fault_idle_req",
          {31'd0, imem_req_valid}, 32'd0);
      chk("fault_sticky", {31'd0, fault}, 32'd1);
    end

    reset_n = 1'b0;
    #1;
    chk("pulse_fault", {31'd0, fault}, 32'd0);
    chk("pulse_retire", retire_cnt, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_ret = 0;
    exp_req = 0;
    fetch(r0, 1'b0);

    chk("wait_addr", imem_addr, 32'h3004);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    reset_n = 1'b1;
    exp_ret = 0;
    exp_req = 0;
    fetch(r0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit directly upstream of the instruction decoder/controller in the MIPS single-cycle-style core. It owns the PC and issues one instruction-memory read at a time over a valid/ready request and valid response handshake. It presents the returned word to decode with a valid/ready handshake. When decode accepts, it computes the next PC from the decoder's npc_op and branch/jump operands.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset
ADDR_W, 32, PC / memory address width (fixed 32 in this core)

Ports:
clk  in  1  core clock, rising edge
reset_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_addr  out  32  word-aligned read address (= pc)
imem_rsp_valid  in  1  read data valid (single cycle pulse)
imem_rsp_data  in  32  read data
instr_valid  out  1  instruction available to decode
instr_ready  in  1  decode consumes instruction this cycle
instr  out  32  fetched instruction
instr_pc  out  32  PC of instr
link_pc  out  32  instr_pc + 4 (jal writeback value)
npc_op  in  3  000 seq, 001 beq, 010 jal, 100 jr (from decoder, valid while instr_valid)
br_eq  in  1  rs == rt for the presented instruction
jr_target  in  32  rs value for jr
fault  out  1  sticky misaligned-target flag
retire_cnt  out  32  instructions accepted by decode

Behaviour:
- State machine: IDLE, REQ, WAIT, HOLD, FAULT. The reset state is IDLE with pc=PC_RESET.
- Reset values: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=PC_RESET, fault=0, retire_cnt=0. All outputs are registered. link_pc is combinational from instr_pc.
- IDLE: on the first clock after reset_n deasserts, go to REQ.
- REQ: imem_req_valid=1, with imem_addr=pc held stable. On imem_req_ready=1, go to WAIT and drop req_valid the next cycle.
- WAIT: on imem_rsp_valid, latch instr=imem_rsp_data and instr_pc=pc, set instr_valid=1, and go to HOLD. The earliest response is 1 cycle after acceptance, so the minimum fetch latency is req-accept + 1.
- imem_rsp_valid outside WAIT is ignored; the data is dropped and the state is unchanged.
- HOLD: instr, instr_pc and instr_valid are held stable until instr_ready=1. On that cycle:
  - retire_cnt increments (wraps 2^32-1 -> 0).
  - npc is computed, pc<=npc, instr_valid<=0, and the state goes to REQ.
- npc rules:
  - 000 or any unlisted code: pc+4.
  - 001: br_eq ? pc + 4 + (sign_extend(instr[15:0]) << 2) : pc+4.
  - 010: {pc[31:28], instr[25:0], 2'b00}.
  - 100: jr_target.
  - All additions are modulo 2^32, so wrap-around is allowed.
- Misaligned npc (npc[1:0]!=0, only possible via jr): fault<=1, pc is not updated, and the state goes to FAULT. FAULT is terminal and issues no requests; only reset exits it.
- At most one outstanding memory request. No speculation, no delay slot.
- Async reset mid-operation (any state): all state and outputs take their reset values immediately. The memory is reset by the same reset_n, so no stale response survives.

Decomposition:
- Shared package: npc_op encodings (NPC_SEQ=3'b000, NPC_BEQ=3'b001, NPC_JAL=3'b010, NPC_JR=3'b100), fetch state enum, PC_RESET constant. The decoder uses the same npc_op constants.
- One natural combinational sub-module, npc_calc: inputs pc, instr, npc_op, br_eq and jr_target; outputs npc and misaligned. The FSM, PC register and counter stay in ifu_fetch.

Test Plan:
- Reset, then imem_req_ready=1 and a response 1 cycle later with 32'h3402_0001 -> imem_addr=32'h3000 in REQ; instr_valid in HOLD with instr_pc=32'h3000 and link_pc=32'h3004; after instr_ready with npc_op=000 -> next imem_addr=32'h3004 and retire_cnt=1.
- Handshake stalls: imem_req_ready low for 3 cycles, response delayed 4 cycles, instr_ready low for 5 cycles -> addr/valid stay stable throughout; exactly one request; instr unchanged until accepted.
- At pc=32'h3010:
  - beq instr 32'h1000_FFFE with br_eq=1 -> next pc 32'h300C.
  - The same instr with br_eq=0 -> 32'h3014.
- jal 32'h0C00_0C10 at pc=32'h3020 -> next pc 32'h0000_3040. jr with jr_target=32'h0000_3100 -> next pc 32'h3100.
- jr with jr_target=32'h0000_3102 -> fault=1, FSM in FAULT, imem_req_valid stays 0 for 10+ cycles; a reset pulse clears fault and the next request is to 32'h3000.
- Spurious imem_rsp_valid in HOLD is ignored. Assert reset_n=0 while in WAIT -> outputs take reset values asynchronously, and after release the fetch restarts at PC_RESET.
